// File: rtl/dma_axi_wr_engine.sv
// Write half of the checkpoint DMA: turns an {addr, count} command plus a word stream
// into AXI4 INCR write bursts, one in flight at a time, never crossing a 4 KiB boundary.
module dma_axi_wr_engine #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 64,
  parameter int COUNT_WIDTH   = 16,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_write_addr_valid,
  output logic                      s_write_addr_ready,
  input  logic [ADDR_WIDTH-1:0]     s_write_addr,
  input  logic                      s_write_count_valid,
  output logic                      s_write_count_ready,
  input  logic [COUNT_WIDTH-1:0]    s_write_count,
  input  logic                      s_write_data_valid,
  output logic                      s_write_data_ready,
  input  logic [DATA_WIDTH-1:0]     s_write_data,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_awlock,
  output logic [3:0]                m_axi_awcache,
  output logic [2:0]                m_axi_awprot,
  output logic [3:0]                m_axi_awqos,
  output logic [3:0]                m_axi_awregion,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wlast,
  input  logic                      m_axi_bvalid,
  input  logic [1:0]                m_axi_bresp,
  output logic                      m_axi_bready,
  output logic                      w_idle,
  output logic                      w_err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  // Common width for the burst-length minimum: holds a full 4 KiB of byte-wide words.
  localparam int CW    = (COUNT_WIDTH > 13) ? COUNT_WIDTH : 13;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

  typedef enum logic [2:0] {IDLE, GOT_ADDR, CALC, AW, W, B} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [COUNT_WIDTH-1:0]  remaining_reg, remaining_next;
  logic [8:0]              len_reg, len_next;
  logic [7:0]              beat_reg, beat_next;
  logic                    err_reg, err_next;
  logic [12:0]             boundary_words;
  logic [CW-1:0]           cap;
  logic                    last_beat;
  logic                    w_hs;

  assign boundary_words = (13'd4096 - {1'b0, addr_reg[11:0]}) >> SIZE;
  assign last_beat      = ({1'b0, beat_reg} == (len_reg - 9'd1));
  assign w_hs           = (state_reg == W) && s_write_data_valid && m_axi_wready;

  // Reset also gates the address ready so nothing is offered while rst is high.
  assign s_write_addr_ready  = (state_reg == IDLE) && !rst;
  assign s_write_count_ready = (state_reg == GOT_ADDR);
  assign s_write_data_ready  = (state_reg == W) && m_axi_wready;

  assign m_axi_awvalid  = (state_reg == AW);
  assign m_axi_awaddr   = addr_reg;
  assign m_axi_awlen    = 8'(len_reg - 9'd1);
  assign m_axi_awsize   = 3'(SIZE);
  assign m_axi_awburst  = 2'b01;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awcache  = 4'd0;
  assign m_axi_awprot   = 3'd0;
  assign m_axi_awqos    = 4'd0;
  assign m_axi_awregion = 4'd0;

  assign m_axi_wvalid = (state_reg == W) && s_write_data_valid;
  assign m_axi_wdata  = s_write_data;
  assign m_axi_wstrb  = '1;
  assign m_axi_wlast  = (state_reg == W) && last_beat;
  assign m_axi_bready = (state_reg == B);

  assign w_idle = (state_reg == IDLE);
  assign w_err  = err_reg;

  always_comb begin
    cap = CW'(MAX_BURST_LEN);
    if (CW'(boundary_words) < cap) cap = CW'(boundary_words);
    if (CW'(remaining_reg) < cap)  cap = CW'(remaining_reg);
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    len_next       = len_reg;
    beat_next      = beat_reg;
    err_next       = err_reg;
    case (state_reg)
      IDLE: if (s_write_addr_valid) begin
        addr_next  = s_write_addr & ALIGN_MASK;
        err_next   = 1'b0;
        state_next = GOT_ADDR;
      end
      GOT_ADDR: if (s_write_count_valid) begin
        remaining_next = s_write_count;
        state_next     = (s_write_count == '0) ? IDLE : CALC;
      end
      CALC: begin
        len_next   = 9'(cap);
        beat_next  = 8'd0;
        state_next = AW;
      end
      AW: if (m_axi_awready) state_next = W;
      W: if (w_hs) begin
        beat_next = beat_reg + 8'd1;
        if (last_beat) state_next = B;
      end
      B: if (m_axi_bvalid) begin
        if (m_axi_bresp != 2'b00) err_next = 1'b1;
        addr_next      = addr_reg + (ADDR_WIDTH'(len_reg) << SIZE);
        remaining_next = remaining_reg - COUNT_WIDTH'(len_reg);
        state_next     = (remaining_next == '0) ? IDLE : CALC;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      len_reg       <= 9'd0;
      beat_reg      <= 8'd0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      len_reg       <= len_next;
      beat_reg      <= beat_next;
      err_reg       <= err_next;
    end
  end

endmodule

// File: tb/tb_dma_axi_wr_engine.sv
// Self-checking bench for dma_axi_wr_engine: directed and randomized commands against a
// burst-list reference model computed from the 4 KiB / max-length splitting rules.
module tb_dma_axi_wr_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_write_addr_valid, s_write_addr_ready;
  logic [31:0] s_write_addr;
  logic        s_write_count_valid, s_write_count_ready;
  logic [15:0] s_write_count;
  logic        s_write_data_valid, s_write_data_ready;
  logic [63:0] s_write_data;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic [3:0]  m_axi_awqos;
  logic [3:0]  m_axi_awregion;
  logic        m_axi_wvalid, m_axi_wready;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_bvalid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bready;
  logic        w_idle, w_err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] addr;
    int          len;
  } burst_t;

  burst_t      exp_q[$];
  logic [63:0] data_q[$];

  always #5 clk = ~clk;

  dma_axi_wr_engine dut (
    .clk(clk), .rst(rst),
    .s_write_addr_valid(s_write_addr_valid), .s_write_addr_ready(s_write_addr_ready),
    .s_write_addr(s_write_addr),
    .s_write_count_valid(s_write_count_valid), .s_write_count_ready(s_write_count_ready),
    .s_write_count(s_write_count),
    .s_write_data_valid(s_write_data_valid), .s_write_data_ready(s_write_data_ready),
    .s_write_data(s_write_data),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
    .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos), .m_axi_awregion(m_axi_awregion),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
    .w_idle(w_idle), .w_err(w_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: split a command into bursts by remaining words, max length and 4 KiB room.
  task automatic build_model(input logic [31:0] a0, input int cnt);
    logic [31:0] a;
    int rem, room, l;
    exp_q.delete();
    data_q.delete();
    a = a0 & ~32'h7;
    rem = cnt;
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 8;
      l = rem;
      if (l > 16) l = 16;
      if (l > room) l = room;
      exp_q.push_back('{addr: a, len: l});
      a = a + 32'(l * 8);
      rem = rem - l;
    end
    for (int i = 0; i < cnt; i++) data_q.push_back({$urandom, $urandom});
  endtask

  task automatic run_cmd(input logic [31:0] a0, input int cnt, input int aw_dly,
                         input int gap, input int err_idx);
    int bi, di, beat, aw_wait, cyc;
    logic aw_acc, aw_first, exp_err;
    build_model(a0, cnt);
    @(negedge clk);
    s_write_addr = a0;
    s_write_addr_valid = 1'b1;
    #1;
    check("addr_ready", s_write_addr_ready, 1);
    @(negedge clk);
    s_write_addr_valid = 1'b0;
    s_write_count = 16'(cnt);
    s_write_count_valid = 1'b1;
    #1;
    check("w_err_cleared", w_err, 0);
    check("count_ready", s_write_count_ready, 1);
    check("busy_after_addr", w_idle, 0);
    @(negedge clk);
    s_write_count_valid = 1'b0;
    #1;
    if (cnt == 0) begin
      check("zero_idle", w_idle, 1);
      check("zero_no_aw", m_axi_awvalid, 0);
      $display("[TB] cmd addr=%08h count=0 bursts=0", a0);
      return;
    end
    check("calc_no_aw", m_axi_awvalid, 0);
    @(negedge clk);
    #1;
    check("aw_latency", m_axi_awvalid, 1);
    bi = 0; di = 0; beat = 0; aw_wait = 0; cyc = 0;
    aw_acc = 1'b0; aw_first = 1'b1; exp_err = 1'b0;
    while (bi < exp_q.size() && cyc < 3000) begin
      m_axi_awready = m_axi_awvalid && (aw_wait >= aw_dly);
      s_write_data_valid = (di < cnt) && ($urandom_range(99) >= gap);
      s_write_data = (di < cnt) ? data_q[di] : 64'd0;
      m_axi_wready = ($urandom_range(99) >= gap);
      m_axi_bvalid = m_axi_bready && ($urandom_range(99) >= gap);
      m_axi_bresp = (bi == err_idx) ? 2'b10 : 2'b00;
      #1;
      if (!aw_acc && m_axi_wready) check("no_data_before_aw", s_write_data_ready, 0);
      if (m_axi_awvalid) begin
        check(aw_first ? "awaddr" : "awaddr_stable", m_axi_awaddr, exp_q[bi].addr);
        check(aw_first ? "awlen" : "awlen_stable", m_axi_awlen, 64'(exp_q[bi].len - 1));
        aw_first = 1'b0;
        aw_wait++;
        if (m_axi_awready) aw_acc = 1'b1;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        check("wdata", m_axi_wdata, data_q[di]);
        check("wlast", m_axi_wlast, 64'(beat == exp_q[bi].len - 1));
        di++;
        beat++;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        check("beats_per_burst", beat, exp_q[bi].len);
        if (bi == err_idx) exp_err = 1'b1;
        bi++;
        beat = 0; aw_wait = 0; aw_acc = 1'b0; aw_first = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    m_axi_awready = 1'b0; s_write_data_valid = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    check("cmd_within_budget", cyc < 3000, 1);
    check("words_written", di, cnt);
    #1;
    check("done_idle", w_idle, 1);
    check("w_err_final", w_err, exp_err);
    $display("[TB] cmd addr=%08h count=%0d bursts=%0d/%0d words=%0d w_err=%0b",
             a0, cnt, bi, exp_q.size(), di, w_err);
  endtask

  initial begin
    int k;
    logic seen;
    rst = 1'b1;
    s_write_addr_valid = 0; s_write_addr = 0; s_write_count_valid = 0; s_write_count = 0;
    s_write_data_valid = 0; s_write_data = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    s_write_data_valid = 1'b1;
    m_axi_wready = 1'b1;
    #1;
    check("rst_idle", w_idle, 1);
    check("rst_err", w_err, 0);
    check("rst_addr_ready", s_write_addr_ready, 0);
    check("rst_count_ready", s_write_count_ready, 0);
    check("rst_data_ready", s_write_data_ready, 0);
    check("rst_awvalid", m_axi_awvalid, 0);
    check("rst_wvalid", m_axi_wvalid, 0);
    check("rst_bready", m_axi_bready, 0);
    rst = 1'b0;
    s_write_data_valid = 1'b0;
    m_axi_wready = 1'b0;
    @(negedge clk);
    #1;
    check("idle_addr_ready", s_write_addr_ready, 1);
    check("awsize", m_axi_awsize, 3);
    check("awburst", m_axi_awburst, 1);
    check("aw_misc", {m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion}, 0);
    check("wstrb", m_axi_wstrb, 8'hFF);

    run_cmd(32'h0000_1000, 4, 0, 0, -1);
    run_cmd(32'h0000_0000, 40, 0, 0, -1);
    run_cmd(32'h0000_0FF0, 4, 0, 0, -1);
    run_cmd(32'h0000_0000, 40, 5, 30, -1);
    run_cmd(32'h0000_0000, 40, 0, 10, 1);
    repeat (3) @(negedge clk);
    #1;
    check("w_err_holds", w_err, 1);
    run_cmd(32'h0000_0500, 0, 0, 0, -1);

    for (int i = 0; i < 6; i++)
      run_cmd($urandom & 32'h0000_3FFF, $urandom_range(1, 60), $urandom_range(0, 3), 20,
              $urandom_range(0, 3));

    // Reset in the middle of a data burst.
    build_model(32'h0000_2000, 8);
    @(negedge clk);
    s_write_addr = 32'h0000_2000; s_write_addr_valid = 1'b1;
    @(negedge clk);
    s_write_addr_valid = 1'b0; s_write_count = 16'd8; s_write_count_valid = 1'b1;
    @(negedge clk);
    s_write_count_valid = 1'b0;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    s_write_data_valid = 1'b1; s_write_data = data_q[0];
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      #1;
      seen = m_axi_wvalid && m_axi_wready;
      @(negedge clk);
      k++;
    end
    check("reached_w", seen, 1);
    rst = 1'b1;
    #1;
    check("addr_ready_in_rst", s_write_addr_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_awvalid", m_axi_awvalid, 0);
    check("rst_mid_wvalid", m_axi_wvalid, 0);
    check("rst_mid_idle", w_idle, 1);
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; s_write_data_valid = 1'b0;
    $display("[TB] reset mid-W after %0d cycles, w_idle=%0b", k, w_idle);
    run_cmd(32'h0000_3FE0, 10, 1, 20, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
